// File: rtl/sar_search4.sv
// -----------------------------------------------------------------------------
// sar_search4 -- successive-approximation search controller
//
// Consumer end of an LG/EQ/SM magnitude-compare handshake. The block presents
// trial values to an external comparator, reads back the one-hot relation
// "unknown X vs TRIAL", and resolves X one bit per probe, MSB first.
//
// Each probe is a TRY/ACK handshake followed by a one-cycle return-to-zero gap
// (TRY low). The comparator may stretch a probe by holding ACK low; TRIAL is
// held stable for as long as TRY is high.
//
// Parameters:
//   WIDTH              width of TRIAL/VALUE and number of probes (>= 1)
//
// Ports:
//   CLK                clock, rising edge
//   RST                asynchronous reset, active-high
//   START              start a search; only honoured while BUSY=0
//   TRY                probe request; TRIAL is valid while high
//   TRIAL[WIDTH-1:0]   trial value presented to the comparator
//   ACK                comparator response valid; only looked at while TRY=1
//   LG_IN              X >  TRIAL
//   EQ_IN              X == TRIAL
//   SM_IN              X <  TRIAL
//   BUSY               search in progress
//   DONE               one-cycle pulse when VALUE/ERR become final
//   VALUE[WIDTH-1:0]   recovered value, held until the next accepted START
//   ERR                last search hit a non-one-hot response, held likewise
//
// Build option:
//   SAR_EARLY_EXIT_EN  when defined, a valid EQ response ends the search at
//                      once with VALUE=TRIAL. When undefined, EQ behaves like
//                      LG (keep the bit) and every search runs WIDTH probes.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module sar_search4 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic             TRY,
    output logic [WIDTH-1:0] TRIAL,
    input  logic             ACK,
    input  logic             LG_IN,
    input  logic             EQ_IN,
    input  logic             SM_IN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] VALUE,
    output logic             ERR
);

    // Bit-index width; a 1-bit search still needs a 1-bit index register.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB_BIT = ONE << (WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        GAP   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state and its next-state values
    // -------------------------------------------------------------------------
    state_t           state,      state_next;
    logic [IDX_W-1:0] idx,        idx_next;
    logic             try_q,      try_next;
    logic [WIDTH-1:0] trial_q,    trial_next;
    logic             busy_q,     busy_next;
    logic             done_q,     done_next;
    logic [WIDTH-1:0] value_q,    value_next;
    logic             err_q,      err_next;

    // -------------------------------------------------------------------------
    // Decode of the comparator response
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] cur_bit;      // mask of the bit under test
    logic [WIDTH-1:0] next_bit;     // mask of the bit tested after this one
    logic [WIDTH-1:0] kept_trial;   // TRIAL after deciding the current bit
    logic             resp_valid;   // exactly one of LG/EQ/SM is set
    logic             early_exit;   // valid EQ ends the search (option only)
    logic             last_bit;     // current bit is bit 0

    assign cur_bit  = ONE << idx;
    assign next_bit = cur_bit >> 1;
    assign last_bit = (idx == '0);

    always_comb begin
        unique case ({LG_IN, EQ_IN, SM_IN})
            3'b100,
            3'b010,
            3'b001:  resp_valid = 1'b1;
            default: resp_valid = 1'b0;
        endcase
    end

    // Only SM clears the bit; LG and EQ both mean X has this bit set.
    assign kept_trial = SM_IN ? (trial_q & ~cur_bit) : trial_q;

`ifdef SAR_EARLY_EXIT_EN
    assign early_exit = EQ_IN;
`else
    assign early_exit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned below gets a default first so that no
        // path through the case statement leaves it unassigned (no latches).
        state_next = state;
        idx_next   = idx;
        try_next   = try_q;
        trial_next = trial_q;
        busy_next  = busy_q;
        done_next  = 1'b0;          // DONE is a single-cycle pulse
        value_next = value_q;
        err_next   = err_q;

        unique case (state)
            IDLE: begin
                if (START) begin
                    state_next = PROBE;
                    idx_next   = IDX_MSB;
                    try_next   = 1'b1;
                    trial_next = MSB_BIT;
                    busy_next  = 1'b1;
                    value_next = '0;
                    err_next   = 1'b0;
                end
            end

            PROBE: begin
                // Without ACK the probe simply stretches: TRY and TRIAL hold.
                if (ACK) begin
                    if (!resp_valid) begin
                        // Report the bits resolved so far; the bit under test
                        // is unknown, so it is reported as 0.
                        err_next   = 1'b1;
                        value_next = trial_q & ~cur_bit;
                        state_next = IDLE;
                        idx_next   = IDX_MSB;
                        try_next   = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (early_exit) begin
                        value_next = trial_q;
                        state_next = IDLE;
                        idx_next   = IDX_MSB;
                        try_next   = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (last_bit) begin
                        value_next = kept_trial;
                        state_next = IDLE;
                        idx_next   = IDX_MSB;
                        try_next   = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // Next trial is prepared during the gap so TRIAL is
                        // already stable when TRY rises again.
                        trial_next = kept_trial | next_bit;
                        idx_next   = idx - IDX_W'(1);
                        try_next   = 1'b0;
                        state_next = GAP;
                    end
                end
            end

            GAP: begin
                // Return-to-zero cycle between probes.
                try_next   = 1'b1;
                state_next = PROBE;
            end

            default: begin
                state_next = IDLE;
                idx_next   = IDX_MSB;
                try_next   = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            idx     <= IDX_MSB;
            try_q   <= 1'b0;
            trial_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            try_q   <= try_next;
            trial_q <= trial_next;
            busy_q  <= busy_next;
            done_q  <= done_next;
            value_q <= value_next;
            err_q   <= err_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign TRY   = try_q;
    assign TRIAL = trial_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign VALUE = value_q;
    assign ERR   = err_q;

endmodule
